// File: rtl/vc_fifo_arbiter.sv
// Two-virtual-channel input buffer with a strict-priority pop arbiter (VC0 over VC1).
// Popped words are presented on registered per-channel outputs with one-hot valids.
module vc_fifo_arbiter #(
    parameter int BITNUMBER = 6,
    parameter int ADDR      = 2,
    parameter int AF_THRESH = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BITNUMBER-1:0] data_in,
    input  logic                 push,
    input  logic                 vc_sel,
    input  logic                 pause,
    output logic [BITNUMBER-1:0] data_out0,
    output logic [BITNUMBER-1:0] data_out1,
    output logic                 valid_VC0,
    output logic                 valid_VC1,
    output logic                 empty0,
    output logic                 empty1,
    output logic                 full0,
    output logic                 full1,
    output logic                 almost_full0,
    output logic                 almost_full1,
    output logic                 error
);

    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1'b1);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1'b1);
    localparam logic [ADDR:0]   CNT_ZERO = (ADDR+1)'(1'b0);
    localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0]   CNT_AF   = (ADDR+1)'(AF_THRESH);

    logic [BITNUMBER-1:0] mem_q [2][DEPTH];
    logic [ADDR-1:0]      wptr_q [2];
    logic [ADDR-1:0]      wptr_d [2];
    logic [ADDR-1:0]      rptr_q [2];
    logic [ADDR-1:0]      rptr_d [2];
    logic [ADDR:0]        cnt_q  [2];
    logic [ADDR:0]        cnt_d  [2];

    logic [BITNUMBER-1:0] data_out0_q;
    logic [BITNUMBER-1:0] data_out1_q;
    logic                 valid0_q;
    logic                 valid1_q;
    logic                 error_q;

    logic [1:0] push_s;
    logic [1:0] pop_s;
    logic [1:0] full_s;
    logic [1:0] wr_s;
    logic [1:0] ovf_s;

    // Pop arbitration on pre-edge occupancy, push acceptance and next pointer/occupancy state
    always_comb begin
        push_s[0] = push & ~vc_sel;
        push_s[1] = push & vc_sel;
        pop_s[0]  = ~pause & (cnt_q[0] != CNT_ZERO);
        pop_s[1]  = ~pause & (cnt_q[0] == CNT_ZERO) & (cnt_q[1] != CNT_ZERO);
        for (int v = 0; v < 2; v++) begin
            full_s[v] = (cnt_q[v] == CNT_FULL);
            // A full FIFO still takes a word when its head leaves on the same edge
            wr_s[v]   = push_s[v] & (~full_s[v] | pop_s[v]);
            ovf_s[v]  = push_s[v] & full_s[v] & ~pop_s[v];
            if (wr_s[v]) begin
                wptr_d[v] = wptr_q[v] + PTR_ONE;
            end else begin
                wptr_d[v] = wptr_q[v];
            end
            if (pop_s[v]) begin
                rptr_d[v] = rptr_q[v] + PTR_ONE;
            end else begin
                rptr_d[v] = rptr_q[v];
            end
            if (wr_s[v] && !pop_s[v]) begin
                cnt_d[v] = cnt_q[v] + CNT_ONE;
            end else if (pop_s[v] && !wr_s[v]) begin
                cnt_d[v] = cnt_q[v] - CNT_ONE;
            end else begin
                cnt_d[v] = cnt_q[v];
            end
        end
    end

    // State update: storage, pointers, occupancy, registered pop outputs and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int v = 0; v < 2; v++) begin
                wptr_q[v] <= '0;
                rptr_q[v] <= '0;
                cnt_q[v]  <= CNT_ZERO;
            end
            data_out0_q <= '0;
            data_out1_q <= '0;
            valid0_q    <= 1'b0;
            valid1_q    <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                if (wr_s[v]) begin
                    mem_q[v][wptr_q[v]] <= data_in;
                end
                wptr_q[v] <= wptr_d[v];
                rptr_q[v] <= rptr_d[v];
                cnt_q[v]  <= cnt_d[v];
            end
            if (pop_s[0]) begin
                data_out0_q <= mem_q[0][rptr_q[0]];
                valid0_q    <= 1'b1;
                valid1_q    <= 1'b0;
            end else if (pop_s[1]) begin
                data_out1_q <= mem_q[1][rptr_q[1]];
                valid0_q    <= 1'b0;
                valid1_q    <= 1'b1;
            end else begin
                valid0_q    <= 1'b0;
                valid1_q    <= 1'b0;
            end
            if (ovf_s[0] || ovf_s[1]) begin
                error_q <= 1'b1;
            end
        end
    end

    assign data_out0    = data_out0_q;
    assign data_out1    = data_out1_q;
    assign valid_VC0    = valid0_q;
    assign valid_VC1    = valid1_q;
    assign error        = error_q;
    assign empty0       = (cnt_q[0] == CNT_ZERO);
    assign empty1       = (cnt_q[1] == CNT_ZERO);
    assign full0        = (cnt_q[0] == CNT_FULL);
    assign full1        = (cnt_q[1] == CNT_FULL);
    assign almost_full0 = (cnt_q[0] >= CNT_AF);
    assign almost_full1 = (cnt_q[1] >= CNT_AF);

endmodule

// File: tb/tb_vc_fifo_arbiter.sv
// Bench for vc_fifo_arbiter: directed vector table, hand sequences for wrap/reset,
// and randomized traffic against a queue-based reference model.
module tb_vc_fifo_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] data_in;
    logic       push;
    logic       vc_sel;
    logic       pause;
    logic [5:0] data_out0;
    logic [5:0] data_out1;
    logic       valid_VC0;
    logic       valid_VC1;
    logic       empty0;
    logic       empty1;
    logic       full0;
    logic       full1;
    logic       almost_full0;
    logic       almost_full1;
    logic       error;

    int checks   = 0;
    int failures = 0;

    vc_fifo_arbiter #(.BITNUMBER(6), .ADDR(2), .AF_THRESH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .push         (push),
        .vc_sel       (vc_sel),
        .pause        (pause),
        .data_out0    (data_out0),
        .data_out1    (data_out1),
        .valid_VC0    (valid_VC0),
        .valid_VC1    (valid_VC1),
        .empty0       (empty0),
        .empty1       (empty1),
        .full0        (full0),
        .full1        (full1),
        .almost_full0 (almost_full0),
        .almost_full1 (almost_full1),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       push;
        logic       vc;
        logic [5:0] din;
        logic       pause;
        logic       v0;
        logic       v1;
        logic [5:0] d0;
        logic [5:0] d1;
        logic       em0;
        logic       em1;
        logic       f0;
        logic       af0;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    // Reference model: plain queues, capacity 4, strict VC0 priority
    logic [5:0] mq0[$];
    logic [5:0] mq1[$];
    logic [5:0] m_d0, m_d1;
    logic       m_v0, m_v1, m_err;

    task automatic model_edge(input logic rst_n, input logic p, input logic vc,
                              input logic [5:0] din, input logic ps);
        int  s0, s1;
        bit  p0, p1;
        if (!rst_n) begin
            mq0.delete(); mq1.delete();
            m_d0 = 6'h00; m_d1 = 6'h00; m_v0 = 1'b0; m_v1 = 1'b0; m_err = 1'b0;
        end else begin
            s0 = mq0.size();
            s1 = mq1.size();
            p0 = !ps && s0 > 0;
            p1 = !ps && s0 == 0 && s1 > 0;
            if (p0) m_d0 = mq0.pop_front();
            if (p1) m_d1 = mq1.pop_front();
            m_v0 = p0;
            m_v1 = p1;
            if (p && !vc) begin
                if (s0 < 4 || p0) mq0.push_back(din); else m_err = 1'b1;
            end
            if (p && vc) begin
                if (s1 < 4 || p1) mq1.push_back(din); else m_err = 1'b1;
            end
        end
    endtask

    function automatic logic [20:0] model_vec();
        return {m_d0, m_d1, m_v0, m_v1, mq0.size() == 0, mq1.size() == 0,
                mq0.size() == 4, mq1.size() == 4, mq0.size() >= 3, mq1.size() >= 3, m_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive one cycle, advance the model at the edge, then compare shortly after the edge
    task automatic step(input logic rst_n, input logic p, input logic vc,
                        input logic [5:0] din, input logic ps);
        logic [20:0] dv;
        reset = rst_n; push = p; vc_sel = vc; data_in = din; pause = ps;
        @(posedge clk);
        model_edge(rst_n, p, vc, din, ps);
        #1;
        dv = {data_out0, data_out1, valid_VC0, valid_VC1, empty0, empty1,
              full0, full1, almost_full0, almost_full1, error};
        chk("model_outputs", 32'(dv), 32'(model_vec()));
        chk("valid_onehot", 32'(valid_VC0 & valid_VC1), 32'd0);
    endtask

    task automatic add(input logic r, input logic p, input logic vc, input logic [5:0] din,
                       input logic ps, input logic v0, input logic v1, input logic [5:0] d0,
                       input logic [5:0] d1, input logic em0, input logic em1,
                       input logic f0, input logic af0, input logic err);
        vec_t e;
        e = '{r, p, vc, din, ps, v0, v1, d0, d1, em0, em1, f0, af0, err};
        tbl.push_back(e);
    endtask

    initial begin
        logic [22:0] act, exp;
        reset = 1'b0; push = 1'b0; vc_sel = 1'b0; data_in = 6'h00; pause = 1'b0;
        //   rst  psh vc   din    ps    v0   v1   d0     d1     em0  em1  f0   af0  err
        // reset held with push active
        add(1'b0,1'b1,1'b0,6'h3F,1'b0, 1'b0,1'b0,6'h00,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b0,1'b1,1'b0,6'h3F,1'b0, 1'b0,1'b0,6'h00,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h00,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);
        // single VC1 word
        add(1'b1,1'b1,1'b1,6'h15,1'b0, 1'b0,1'b0,6'h00,6'h00, 1'b1,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b1,6'h00,6'h15, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h00,6'h15, 1'b1,1'b1,1'b0,1'b0,1'b0);
        // priority: preload under pause, then release
        add(1'b1,1'b1,1'b0,6'h01,1'b1, 1'b0,1'b0,6'h00,6'h15, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h02,1'b1, 1'b0,1'b0,6'h00,6'h15, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b1,6'h21,1'b1, 1'b0,1'b0,6'h00,6'h15, 1'b0,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h01,6'h15, 1'b0,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h02,6'h15, 1'b1,1'b0,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b1,6'h02,6'h21, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h02,6'h21, 1'b1,1'b1,1'b0,1'b0,1'b0);
        // pause and fill VC0, overflow on the fifth push
        add(1'b1,1'b1,1'b0,6'h0A,1'b1, 1'b0,1'b0,6'h02,6'h21, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h0B,1'b1, 1'b0,1'b0,6'h02,6'h21, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h0C,1'b1, 1'b0,1'b0,6'h02,6'h21, 1'b0,1'b1,1'b0,1'b1,1'b0);
        add(1'b1,1'b1,1'b0,6'h0D,1'b1, 1'b0,1'b0,6'h02,6'h21, 1'b0,1'b1,1'b1,1'b1,1'b0);
        add(1'b1,1'b1,1'b0,6'h0E,1'b1, 1'b0,1'b0,6'h02,6'h21, 1'b0,1'b1,1'b1,1'b1,1'b1);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h0A,6'h21, 1'b0,1'b1,1'b0,1'b1,1'b1);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h0B,6'h21, 1'b0,1'b1,1'b0,1'b0,1'b1);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h0C,6'h21, 1'b0,1'b1,1'b0,1'b0,1'b1);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h0D,6'h21, 1'b1,1'b1,1'b0,1'b0,1'b1);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h0D,6'h21, 1'b1,1'b1,1'b0,1'b0,1'b1);
        // full FIFO with simultaneous push and pop
        add(1'b0,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h00,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h11,1'b1, 1'b0,1'b0,6'h00,6'h00, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h12,1'b1, 1'b0,1'b0,6'h00,6'h00, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b1,1'b0,6'h13,1'b1, 1'b0,1'b0,6'h00,6'h00, 1'b0,1'b1,1'b0,1'b1,1'b0);
        add(1'b1,1'b1,1'b0,6'h14,1'b1, 1'b0,1'b0,6'h00,6'h00, 1'b0,1'b1,1'b1,1'b1,1'b0);
        add(1'b1,1'b1,1'b0,6'h33,1'b0, 1'b1,1'b0,6'h11,6'h00, 1'b0,1'b1,1'b1,1'b1,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h12,6'h00, 1'b0,1'b1,1'b0,1'b1,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h13,6'h00, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h14,6'h00, 1'b0,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b1,1'b0,6'h33,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);
        add(1'b1,1'b0,1'b0,6'h00,1'b0, 1'b0,1'b0,6'h33,6'h00, 1'b1,1'b1,1'b0,1'b0,1'b0);

        repeat (2) @(negedge clk);
        foreach (tbl[i]) begin
            step(tbl[i].rst_n, tbl[i].push, tbl[i].vc, tbl[i].din, tbl[i].pause);
            act = {valid_VC0, valid_VC1, data_out0, data_out1, empty0, empty1,
                   full0, almost_full0, error};
            exp = {tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].em0, tbl[i].em1,
                   tbl[i].f0, tbl[i].af0, tbl[i].err};
            chk($sformatf("table_row%0d", i), 32'(act), 32'(exp));
        end

        // Stream ten words through VC1 across the pointer wrap
        for (int i = 0; i <= 10; i++) begin
            step(1'b1, i < 10, 1'b1, 6'(32 + i), 1'b0);
            if (i > 0) begin
                chk($sformatf("wrap_word%0d", i - 1), 32'({valid_VC1, data_out1}),
                    32'({1'b1, 6'(32 + i - 1)}));
            end
        end

        // Reset with two words buffered discards them
        step(1'b1, 1'b1, 1'b1, 6'h2A, 1'b1);
        step(1'b1, 1'b1, 1'b1, 6'h2B, 1'b1);
        chk("mid_buffered", 32'(empty1), 32'd0);
        step(1'b0, 1'b0, 1'b0, 6'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 6'h00, 1'b0);
        chk("mid_reset_discard", 32'({valid_VC0, valid_VC1, empty1, data_out1}),
            32'({1'b0, 1'b0, 1'b1, 6'h00}));

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)),
                 $urandom_range(0, 2) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
